// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command sequencer.
// Holds unit-select codes, FSM state encoding and a unit decode helper.
package alu_pkg;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_e;

    // Upper two function bits pick the ALU unit.
    function automatic logic [1:0] unit_of(input logic [3:0] fun);
        return fun[3:2];
    endfunction

endpackage

// File: rtl/alu_result_mux.sv
// alu_result_mux: picks one ALU unit's result, flag and carry by unit code.
// Ports: unit_i select; per-unit results/flags in; data_o/flag_o/carry_o out.
module alu_result_mux
    import alu_pkg::*;
#(
    parameter int out_width = 16
) (
    input  logic [1:0]           unit_i,
    input  logic [out_width-1:0] arith_i,
    input  logic [out_width-1:0] logic_i,
    input  logic [out_width-1:0] cmp_i,
    input  logic [out_width-1:0] shift_i,
    input  logic                 carry_i,
    input  logic                 arith_flag_i,
    input  logic                 logic_flag_i,
    input  logic                 cmp_flag_i,
    input  logic                 shift_flag_i,
    output logic [out_width-1:0] data_o,
    output logic                 flag_o,
    output logic                 carry_o
);

    always_comb begin
        data_o  = arith_i;
        flag_o  = arith_flag_i;
        carry_o = 1'b0;
        case (unit_i)
            UNIT_ARITH: begin
                data_o  = arith_i;
                flag_o  = arith_flag_i;
                // Carry only has meaning for the arithmetic unit.
                carry_o = carry_i;
            end
            UNIT_LOGIC: begin
                data_o = logic_i;
                flag_o = logic_flag_i;
            end
            UNIT_CMP: begin
                data_o = cmp_i;
                flag_o = cmp_flag_i;
            end
            UNIT_SHIFT: begin
                data_o = shift_i;
                flag_o = shift_flag_i;
            end
            default: begin
                data_o = arith_i;
                flag_o = arith_flag_i;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: one-at-a-time command initiator for the ALU.
// Ports: CLK/RST; cmd_* valid/ready in; rsp_* valid/ready out;
//        alu_a/b/fun to ALU; alu_*_out/flags from ALU; busy; op_count.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int in_width    = 8,
    parameter int out_width   = 16,
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [in_width-1:0]  cmd_a,
    input  logic [in_width-1:0]  cmd_b,
    input  logic [3:0]           cmd_fun,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [out_width-1:0] rsp_data,
    output logic                 rsp_flag,
    output logic                 rsp_carry,
    output logic [3:0]           rsp_fun,
    output logic [in_width-1:0]  alu_a,
    output logic [in_width-1:0]  alu_b,
    output logic [3:0]           alu_fun,
    input  logic [out_width-1:0] alu_arith_out,
    input  logic [out_width-1:0] alu_logic_out,
    input  logic [out_width-1:0] alu_cmp_out,
    input  logic [out_width-1:0] alu_shift_out,
    input  logic                 alu_carry,
    input  logic                 alu_arith_flag,
    input  logic                 alu_logic_flag,
    input  logic                 alu_cmp_flag,
    input  logic                 alu_shift_flag,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam int LAT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LATENCY - 1);

    seq_state_e state_q, state_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [in_width-1:0]  alu_a_q, alu_b_q;
    logic [3:0]           alu_fun_q;
    logic [out_width-1:0] rsp_data_q;
    logic                 rsp_flag_q, rsp_carry_q;
    logic [3:0]           rsp_fun_q;
    logic [CNT_W-1:0]     op_count_q;

    logic                 load_en, cap_en, done_en;
    logic [out_width-1:0] mux_data;
    logic                 mux_flag, mux_carry;

    alu_result_mux #(
        .out_width (out_width)
    ) u_mux (
        .unit_i       (unit_of(alu_fun_q)),
        .arith_i      (alu_arith_out),
        .logic_i      (alu_logic_out),
        .cmp_i        (alu_cmp_out),
        .shift_i      (alu_shift_out),
        .carry_i      (alu_carry),
        .arith_flag_i (alu_arith_flag),
        .logic_flag_i (alu_logic_flag),
        .cmp_flag_i   (alu_cmp_flag),
        .shift_flag_i (alu_shift_flag),
        .data_o       (mux_data),
        .flag_o       (mux_flag),
        .carry_o      (mux_carry)
    );

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        cmd_ready = 1'b0;
        load_en   = 1'b0;
        cap_en    = 1'b0;
        done_en   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load_en = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                // ALU is free-running; only this exit cycle sees our result.
                if (lat_q == '0) begin
                    cap_en  = 1'b1;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                // A new command may ride the same edge as the response handshake.
                cmd_ready = rsp_ready;
                if (rsp_ready) begin
                    done_en = 1'b1;
                    if (cmd_valid) begin
                        load_en = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            rsp_data_q  <= '0;
            rsp_flag_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
            rsp_fun_q   <= '0;
            op_count_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (load_en) begin
                alu_a_q   <= cmd_a;
                alu_b_q   <= cmd_b;
                alu_fun_q <= cmd_fun;
            end
            if (cap_en) begin
                rsp_data_q  <= mux_data;
                rsp_flag_q  <= mux_flag;
                rsp_carry_q <= mux_carry;
                rsp_fun_q   <= alu_fun_q;
            end
            if (done_en) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_flag  = rsp_flag_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_fun   = rsp_fun_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fun   = alu_fun_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized bench for alu_op_sequencer.
// Instance A: latency 1, 16-bit counter; instance B: latency 3, 4-bit counter.
module tb_alu_op_sequencer;

    logic       CLK, RST, cmd_valid, rsp_ready, cforce;
    logic [7:0] cmd_a, cmd_b;
    logic [3:0] cmd_fun;

    logic        rdy_a, rv_a, rf_a, rc_a, busy_a;
    logic [15:0] rd_a, cnt_a;
    logic [3:0]  rfun_a, afun_a;
    logic [7:0]  aa_a, ab_a;
    logic [68:0] pa;

    logic        rdy_b, rv_b, rf_b, rc_b, busy_b;
    logic [15:0] rd_b;
    logic [3:0]  cnt_b, rfun_b, afun_b;
    logic [7:0]  aa_b, ab_b;
    logic [68:0] pb [3];

    int ncmp = 0;
    int nerr = 0;

    // Behavioural ALU: every unit computes every cycle.
    // Layout: arith, logic, cmp, shift (16b each), carry, arith/logic/cmp/shift flags.
    function automatic logic [68:0] alu_eval(logic [7:0] a, logic [7:0] b, logic cf);
        logic [8:0]  s;
        logic [15:0] sh;
        s  = {1'b0, a} + {1'b0, b};
        sh = {a, b};
        sh = sh << 1;
        return {{7'd0, s}, {a & b, a | b}, {8'hC0, a ^ b}, sh,
                s[8] | cf, s[7:0] == 8'd0, ^(a & b), a < b, a[7]};
    endfunction

    // Expected {data, flag, carry} for a command.
    function automatic logic [17:0] exp_rsp(logic [7:0] a, logic [7:0] b,
                                            logic [3:0] f, logic cf);
        logic [68:0] v;
        v = alu_eval(a, b, cf);
        case (f[3:2])
            2'b00:   return {v[68:53], v[3], v[4]};
            2'b01:   return {v[52:37], v[2], 1'b0};
            2'b10:   return {v[36:21], v[1], 1'b0};
            default: return {v[20:5], v[0], 1'b0};
        endcase
    endfunction

    always_ff @(posedge CLK) pa <= alu_eval(aa_a, ab_a, cforce);

    always_ff @(posedge CLK) begin
        pb[0] <= alu_eval(aa_b, ab_b, cforce);
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end

    alu_op_sequencer #(
        .in_width(8), .out_width(16), .ALU_LATENCY(1), .CNT_W(16)
    ) dut_a (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(rdy_a),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
        .rsp_valid(rv_a), .rsp_ready(rsp_ready),
        .rsp_data(rd_a), .rsp_flag(rf_a), .rsp_carry(rc_a), .rsp_fun(rfun_a),
        .alu_a(aa_a), .alu_b(ab_a), .alu_fun(afun_a),
        .alu_arith_out(pa[68:53]), .alu_logic_out(pa[52:37]),
        .alu_cmp_out(pa[36:21]), .alu_shift_out(pa[20:5]),
        .alu_carry(pa[4]), .alu_arith_flag(pa[3]), .alu_logic_flag(pa[2]),
        .alu_cmp_flag(pa[1]), .alu_shift_flag(pa[0]),
        .busy(busy_a), .op_count(cnt_a)
    );

    alu_op_sequencer #(
        .in_width(8), .out_width(16), .ALU_LATENCY(3), .CNT_W(4)
    ) dut_b (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(rdy_b),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
        .rsp_valid(rv_b), .rsp_ready(rsp_ready),
        .rsp_data(rd_b), .rsp_flag(rf_b), .rsp_carry(rc_b), .rsp_fun(rfun_b),
        .alu_a(aa_b), .alu_b(ab_b), .alu_fun(afun_b),
        .alu_arith_out(pb[2][68:53]), .alu_logic_out(pb[2][52:37]),
        .alu_cmp_out(pb[2][36:21]), .alu_shift_out(pb[2][20:5]),
        .alu_carry(pb[2][4]), .alu_arith_flag(pb[2][3]), .alu_logic_flag(pb[2][2]),
        .alu_cmp_flag(pb[2][1]), .alu_shift_flag(pb[2][0]),
        .busy(busy_b), .op_count(cnt_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic f_rdy(int i);
        return (i == 0) ? rdy_a : rdy_b;
    endfunction

    function automatic logic f_rv(int i);
        return (i == 0) ? rv_a : rv_b;
    endfunction

    task automatic rst_both();
        @(negedge CLK);
        RST = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Offer a command from a negedge; returns at the negedge after the accept edge.
    task automatic send(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] f, output bit ok);
        cmd_a = a;
        cmd_b = b;
        cmd_fun = f;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            #1;
            if (f_rdy(i)) ok = 1'b1;
            @(negedge CLK);
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            ncmp++;
            nerr++;
            $display("FAIL send_timeout inst%0d: cmd_ready got 0, required 1", i);
        end
    endtask

    // Called at the first negedge after accept; lat counts cycles after the accept cycle.
    task automatic wait_rsp(input int i, output int lat);
        bit ok;
        lat = 1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (f_rv(i)) ok = 1'b1;
            else begin
                @(negedge CLK);
                lat++;
            end
        end
        if (!ok) begin
            ncmp++;
            nerr++;
            $display("FAIL rsp_timeout inst%0d: rsp_valid got 0, required 1", i);
        end
    endtask

    task automatic test_reset();
        bit ok;
        int lat;
        bit seen;
        rst_both();
        ncmp++;
        if ({rv_a, rdy_a, busy_a} !== 3'b010) begin
            nerr++;
            $display("FAIL reset_ctrl: got %b, required 010", {rv_a, rdy_a, busy_a});
        end
        ncmp++;
        if (cnt_a !== 16'd0) begin
            nerr++;
            $display("FAIL reset_count: got %0d, required 0", cnt_a);
        end
        ncmp++;
        if ({rd_a, rf_a, rc_a, rfun_a, aa_a, ab_a, afun_a} !== 42'd0) begin
            nerr++;
            $display("FAIL reset_regs: got %h, required 0",
                     {rd_a, rf_a, rc_a, rfun_a, aa_a, ab_a, afun_a});
        end
        rsp_ready = 1'b1;
        send(0, 8'd5, 8'd7, 4'b0000, ok);
        wait_rsp(0, lat);
        @(negedge CLK);
        ncmp++;
        if (cnt_a !== 16'd1) begin
            nerr++;
            $display("FAIL reset_precount: got %0d, required 1", cnt_a);
        end
        send(0, 8'd9, 8'd3, 4'b0100, ok);
        @(negedge CLK);
        ncmp++;
        if ({busy_a, rv_a} !== 2'b10) begin
            nerr++;
            $display("FAIL reset_midwait: got %b, required 10", {busy_a, rv_a});
        end
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        ncmp++;
        if ({rv_a, rdy_a, busy_a, cnt_a} !== {3'b010, 16'd0}) begin
            nerr++;
            $display("FAIL reset_after: got %h, required %h",
                     {rv_a, rdy_a, busy_a, cnt_a}, {3'b010, 16'd0});
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (rv_a) seen = 1'b1;
        end
        ncmp++;
        if (seen !== 1'b0) begin
            nerr++;
            $display("FAIL reset_no_rsp: got rsp_valid 1, required 0");
        end
    endtask

    task automatic test_arith();
        bit ok;
        int lat;
        logic [17:0] e;
        rst_both();
        rsp_ready = 1'b1;
        cforce = 1'b0;
        send(0, 8'd200, 8'd100, 4'b0000, ok);
        wait_rsp(0, lat);
        e = exp_rsp(8'd200, 8'd100, 4'b0000, 1'b0);
        ncmp++;
        if (lat !== 3) begin
            nerr++;
            $display("FAIL arith_latency: got %0d, required 3", lat);
        end
        ncmp++;
        if (rd_a !== 16'h012C) begin
            nerr++;
            $display("FAIL arith_data: got %h, required 012c", rd_a);
        end
        ncmp++;
        if ({rf_a, rc_a, rfun_a} !== {e[1:0], 4'b0000}) begin
            nerr++;
            $display("FAIL arith_flags: got %b, required %b",
                     {rf_a, rc_a, rfun_a}, {e[1:0], 4'b0000});
        end
        @(negedge CLK);
    endtask

    task automatic test_units();
        bit ok;
        int lat;
        logic [17:0] e;
        logic [7:0] a, b;
        logic [3:0] funs [3];
        funs[0] = 4'b0100;
        funs[1] = 4'b1000;
        funs[2] = 4'b1100;
        rst_both();
        rsp_ready = 1'b1;
        cforce = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            send(0, a, b, funs[j], ok);
            wait_rsp(0, lat);
            e = exp_rsp(a, b, funs[j], 1'b1);
            ncmp++;
            if ({rd_a, rf_a, rfun_a} !== {e[17:1], funs[j]}) begin
                nerr++;
                $display("FAIL unit_data fun=%b: got %h, required %h",
                         funs[j], {rd_a, rf_a, rfun_a}, {e[17:1], funs[j]});
            end
            ncmp++;
            if (rc_a !== 1'b0) begin
                nerr++;
                $display("FAIL unit_carry fun=%b: got %b, required 0", funs[j], rc_a);
            end
            @(negedge CLK);
        end
        cforce = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [17:0] e1, e2;
        logic [7:0] a1, b1, a2, b2;
        logic [3:0] f1, f2;
        a1 = 8'($urandom); b1 = 8'($urandom); f1 = 4'($urandom);
        a2 = 8'($urandom); b2 = 8'($urandom); f2 = 4'($urandom);
        e1 = exp_rsp(a1, b1, f1, 1'b0);
        e2 = exp_rsp(a2, b2, f2, 1'b0);
        rst_both();
        send(0, a1, b1, f1, ok);
        wait_rsp(0, lat);
        cmd_a = a2;
        cmd_b = b2;
        cmd_fun = f2;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            #1;
            ncmp++;
            if ({rv_a, rd_a, rf_a, rc_a, rfun_a, rdy_a} !== {1'b1, e1, f1, 1'b0}) begin
                nerr++;
                $display("FAIL bp_hold cyc%0d: got %h, required %h", k,
                         {rv_a, rd_a, rf_a, rc_a, rfun_a, rdy_a}, {1'b1, e1, f1, 1'b0});
            end
        end
        rsp_ready = 1'b1;
        #1;
        ncmp++;
        if (rdy_a !== 1'b1) begin
            nerr++;
            $display("FAIL bp_ready: got %b, required 1", rdy_a);
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
        ncmp++;
        if ({rv_a, busy_a, cnt_a, aa_a, ab_a, afun_a} !== {2'b01, 16'd1, a2, b2, f2}) begin
            nerr++;
            $display("FAIL bp_b2b_issue: got %h, required %h",
                     {rv_a, busy_a, cnt_a, aa_a, ab_a, afun_a}, {2'b01, 16'd1, a2, b2, f2});
        end
        wait_rsp(0, lat);
        ncmp++;
        if (lat !== 3 || {rd_a, rf_a, rc_a, rfun_a} !== {e2, f2}) begin
            nerr++;
            $display("FAIL bp_second: got lat %0d data %h, required lat 3 data %h",
                     lat, {rd_a, rf_a, rc_a, rfun_a}, {e2, f2});
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        logic [21:0] q [$];
        logic [21:0] got, want;
        int acc30, nrsp;
        bit took;
        rst_both();
        acc30 = 0;
        nrsp = 0;
        rsp_ready = 1'b1;
        cmd_a = 8'($urandom);
        cmd_b = 8'($urandom);
        cmd_fun = 4'($urandom);
        cmd_valid = 1'b1;
        for (int c = 0; c < 120; c++) begin
            rsp_ready = (c >= 30 && c < 75) ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (rv_a && rsp_ready) begin
                got = {rd_a, rf_a, rc_a, rfun_a};
                ncmp++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL b2b_extra: got response %h, required none", got);
                end else begin
                    want = q.pop_front();
                    if (got !== want) begin
                        nerr++;
                        $display("FAIL b2b_rsp %0d: got %h, required %h", nrsp, got, want);
                    end
                end
                nrsp++;
            end
            took = cmd_valid && rdy_a;
            if (took) begin
                q.push_back({exp_rsp(cmd_a, cmd_b, cmd_fun, 1'b0), cmd_fun});
                if (c < 30) acc30++;
            end
            @(posedge CLK);
            #1;
            if (took) begin
                cmd_a = 8'($urandom);
                cmd_b = 8'($urandom);
                cmd_fun = 4'($urandom);
                cmd_valid = (c < 75);
            end
            @(negedge CLK);
        end
        cmd_valid = 1'b0;
        ncmp++;
        if (acc30 !== 10) begin
            nerr++;
            $display("FAIL b2b_throughput: got %0d accepts, required 10", acc30);
        end
        ncmp++;
        if (q.size() !== 0 || cnt_a !== 16'(nrsp)) begin
            nerr++;
            $display("FAIL b2b_drain: got %0d pending count %0d, required 0 pending count %0d",
                     q.size(), cnt_a, nrsp);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int lat;
        rst_both();
        rsp_ready = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            send(1, 8'($urandom), 8'($urandom), 4'($urandom), ok);
            wait_rsp(1, lat);
            @(negedge CLK);
            ncmp++;
            if (cnt_b !== 4'(k % 16)) begin
                nerr++;
                $display("FAIL wrap_count op%0d: got %0d, required %0d", k, cnt_b, k % 16);
            end
        end
    endtask

    task automatic test_lat3();
        bit ok;
        int lat;
        logic [7:0] a, b;
        logic [3:0] f;
        logic [17:0] e;
        rst_both();
        rsp_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            f = 4'($urandom);
            e = exp_rsp(a, b, f, 1'b0);
            send(1, a, b, f, ok);
            wait_rsp(1, lat);
            ncmp++;
            if (lat !== 5) begin
                nerr++;
                $display("FAIL lat3_latency op%0d: got %0d, required 5", j, lat);
            end
            ncmp++;
            if ({rd_b, rf_b, rc_b, rfun_b} !== {e, f}) begin
                nerr++;
                $display("FAIL lat3_data op%0d: got %h, required %h",
                         j, {rd_b, rf_b, rc_b, rfun_b}, {e, f});
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        RST = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cforce = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_fun = '0;
        test_reset();
        test_arith();
        test_units();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_lat3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
